irda_link_scheduler: RTL and testbench
======================================

Name: irda_link_scheduler

Overview:
- Parametrised half-duplex scheduler for the UART-to-IrDA bridge.
- Replaces the fixed 8-bit FIFO control, the transmit sync logic and the IR echo blanking with one block.
- Buffers bytes from the UART receiver and launches them into the IR transmitter only when the IR link and UART return path are quiet.
- Blanks the IR receive line while the block's own transmission is in flight and for a programmable turnaround guard afterwards.

Parameters:
- DATA_W, 8: byte/word width.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- GUARD_CYCLES, 16: clock cycles the RX line stays blanked after the IR transmitter returns idle; range 1..65535.
- ACK_TIMEOUT, 8: cycles to wait for the IR transmitter to go busy after send; range 1..255.
- RX_IDLE, 1'b0: level driven on ir_rx_gated while blanked.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_data  in  1  one-cycle write strobe from the UART receiver.
- in_data  in  DATA_W  byte accompanying wr_data.
- tx_available  in  1  IR transmitter idle (1) / busy (0).
- rx_busy  in  1  IR receiver mid-frame.
- uart_tx_available  in  1  return-path UART transmitter idle.
- ir_rx_raw  in  1  raw IR receive line.
- ovf_clr  in  1  clears the sticky overflow and drop flags.
- send  out  1  one-cycle launch pulse to the IR transmitter.
- out_data  out  DATA_W  byte for the IR transmitter; held stable from SEND until the next launch.
- ir_rx_gated  out  1  IR line to the IR receiver.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky: a write was lost.
- tx_drop  out  1  sticky: the transmitter never acknowledged a launch.

Behaviour:
- Reset values (reset=0, asynchronous):
  - FIFO pointers and count = 0; empty=1, full=0.
  - send=0, out_data=0, overflow=0, tx_drop=0.
  - State = IDLE, guard counter = 0.
  - ir_rx_gated transparent (follows ir_rx_raw).
- FIFO behaviour:
  - Write when wr_data=1 and not full; pointers wrap modulo DEPTH.
  - Write while full with no pop in the same cycle: data dropped, overflow set on the next edge.
  - Write and pop in the same cycle: both take effect and count is unchanged; this holds even when full.
  - Pop only occurs on the IDLE->SEND transition.
- State machine:
  - IDLE: if !empty && tx_available && !rx_busy && uart_tx_available, pop the head into out_data and go to SEND.
  - SEND: send=1 for exactly this one cycle; go to WAIT_ACK and load the timeout counter with ACK_TIMEOUT.
  - WAIT_ACK: on tx_available=0 go to WAIT_DONE. If the counter reaches 0 first, set tx_drop, discard the byte and go to GUARD.
  - WAIT_DONE: on tx_available=1 go to GUARD and load the guard counter with GUARD_CYCLES.
  - GUARD: decrement each cycle; at 1, return to IDLE on the next edge.
- Latency: with the IDLE conditions met, wr_data sampled at edge k into an empty FIFO gives count=1 after edge k, send high during the cycle after edge k+1, and out_data valid at that same time.
- Blanking:
  - ir_rx_gated = RX_IDLE whenever state is not IDLE; ir_rx_gated = ir_rx_raw in IDLE.
  - ir_rx_gated is a combinational mux on a registered state bit; it introduces no extra delay.
- rx_busy or !uart_tx_available asserted in IDLE holds launches indefinitely; the FIFO keeps accepting writes.
- ovf_clr has priority over a same-cycle set, so the flag reads 0 after that edge.
- Reset mid-transfer aborts immediately, empties the FIFO and reopens the RX gate; no send pulse is generated on exit.
- All arithmetic is unsigned. The guard counter is 16 bits wide and the timeout counter 8 bits wide.

Decomposition:
- Shared header irda_link_defs.vh holds:
  - state encodings: IDLE=0, SEND=1, WAIT_ACK=2, WAIT_DONE=3, GUARD=4, 3 bits;
  - the default RX_IDLE level;
  - the clog2 helper function.
- One sub-module, link_fifo (parametrised synchronous FIFO, DATA_W/DEPTH):
  - ports: push, pop, din, dout, empty, full, count, overflow detect;
  - reused later for the IR-to-UART direction.

Test Plan:
- Single byte:
  - Stimulus: after reset, wr_data with in_data=8'hA5; transmitter model goes busy 2 cycles after send and idle 50 cycles later.
  - Response: send is a single pulse 2 cycles after the write with out_data=8'hA5; ir_rx_gated=RX_IDLE from SEND until GUARD_CYCLES=16 cycles after tx_available returns high.
- Fill and overflow:
  - Stimulus: rx_busy=1 with 17 writes, bytes 8'h00..8'h10.
  - Response: count=16, full=1, overflow=1; after releasing rx_busy, bytes 00..0F are sent in order and 8'h10 is never sent.
- Simultaneous push and pop at full:
  - Stimulus: FIFO full, write in the same cycle as the IDLE->SEND pop.
  - Response: count stays 16, overflow stays 0, and the new byte is sent last.
- Acknowledge timeout:
  - Stimulus: tx_available held at 1 after send.
  - Response: tx_drop=1 ACK_TIMEOUT=8 cycles after send, then GUARD, then the next byte is launched; ovf_clr clears tx_drop.
- Reset mid-transfer:
  - Stimulus: reset low during WAIT_DONE with 3 bytes queued.
  - Response: asynchronously empty=1, count=0, send=0, ir_rx_gated follows ir_rx_raw; after release, no launch occurs without a new write.

Source files
------------

// File: rtl/irda_link_scheduler_pkg.sv
// Shared definitions for the UART-to-IrDA link scheduler: FSM encoding,
// default blanking level and a constant-width helper.
package irda_link_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GUARD     = 3'd4
  } link_state_t;

  localparam logic RX_IDLE_DEFAULT = 1'b0;

  // Ceiling log2, usable in port and parameter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = 32'(i) + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/irda_link_scheduler_fifo.sv
// Parametrised synchronous FIFO with first-word fall-through output; shared by
// both bridge directions.
module link_fifo
  import irda_link_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          empty,
  output logic                          full,
  output logic [clog2(DEPTH+1)-1:0]     count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot the push lands in, so a full FIFO still accepts it.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign dout     = mem[rd_ptr];
  assign count    = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define validity, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/irda_link_scheduler.sv
// Half-duplex UART-to-IrDA scheduler: buffers UART bytes, launches them when the
// link is quiet, and blanks the IR receive line during and after our own frames.
module irda_link_scheduler
  import irda_link_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT  = 8,
  parameter logic        RX_IDLE      = RX_IDLE_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_data,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      tx_available,
  input  logic                      rx_busy,
  input  logic                      uart_tx_available,
  input  logic                      ir_rx_raw,
  input  logic                      ovf_clr,
  output logic                      send,
  output logic [DATA_W-1:0]         out_data,
  output logic                      ir_rx_gated,
  output logic                      empty,
  output logic                      full,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      overflow,
  output logic                      tx_drop
);

  link_state_t       state_q;
  link_state_t       state_d;
  logic [7:0]        timeout_q;
  logic [7:0]        timeout_d;
  logic [15:0]       guard_q;
  logic [15:0]       guard_d;
  logic              pop;
  logic              ack_lost;
  logic              fifo_ovf;
  logic [DATA_W-1:0] fifo_dout;

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_data),
    .pop      (pop),
    .din      (in_data),
    .dout     (fifo_dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (fifo_ovf)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    guard_d   = guard_q;
    pop       = 1'b0;
    ack_lost  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_available && !rx_busy && uart_tx_available) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        timeout_d = 8'(ACK_TIMEOUT);
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!tx_available) begin
          state_d = WAIT_DONE;
        end else if (timeout_q <= 8'd1) begin
          // Counter would hit zero: the transmitter never took the byte.
          timeout_d = '0;
          ack_lost  = 1'b1;
          guard_d   = 16'(GUARD_CYCLES);
          state_d   = GUARD;
        end else begin
          timeout_d = timeout_q - 8'd1;
        end
      end
      WAIT_DONE: begin
        if (tx_available) begin
          guard_d = 16'(GUARD_CYCLES);
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (guard_q <= 16'd1) begin
          guard_d = '0;
          state_d = IDLE;
        end else begin
          guard_d = guard_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timeout_q <= '0;
      guard_q   <= '0;
      send      <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      tx_drop   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      guard_q   <= guard_d;
      send      <= pop;
      if (pop) out_data <= fifo_dout;
      // Clear wins over a same-cycle set so software never misses a clear.
      if (ovf_clr)       overflow <= 1'b0;
      else if (fifo_ovf) overflow <= 1'b1;
      if (ovf_clr)       tx_drop  <= 1'b0;
      else if (ack_lost) tx_drop  <= 1'b1;
    end
  end

  assign ir_rx_gated = (state_q == IDLE) ? ir_rx_raw : RX_IDLE;

endmodule

// File: tb/tb_irda_link_scheduler.sv
// Self-checking bench for irda_link_scheduler: table-driven FIFO vectors, a
// byte scoreboard on every launch, and hand-written timing sequences.
module tb_irda_link_scheduler;

  localparam int   DEPTH   = 16;
  localparam int   GUARD   = 16;
  localparam int   ACK     = 8;
  localparam logic RX_IDLE = 1'b0;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_data;
  logic [7:0] in_data;
  logic       tx_available;
  logic       rx_busy;
  logic       uart_tx_available;
  logic       ir_rx_raw;
  logic       ovf_clr;
  logic       send;
  logic [7:0] out_data;
  logic       ir_rx_gated;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       tx_drop;

  irda_link_scheduler dut (
    .clock             (clock),
    .reset             (reset),
    .wr_data           (wr_data),
    .in_data           (in_data),
    .tx_available      (tx_available),
    .rx_busy           (rx_busy),
    .uart_tx_available (uart_tx_available),
    .ir_rx_raw         (ir_rx_raw),
    .ovf_clr           (ovf_clr),
    .send              (send),
    .out_data          (out_data),
    .ir_rx_gated       (ir_rx_gated),
    .empty             (empty),
    .full              (full),
    .count             (count),
    .overflow          (overflow),
    .tx_drop           (tx_drop)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         send_count = 0;
  logic [7:0] exp_q[$];
  bit         ack_mode = 1'b1;
  int         busy_len = 5;
  int         rise;
  int         sends;
  bit         seen_busy;
  int         lat;
  int         sc;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic       accept;
    logic [4:0] count;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_send(input int budget);
    for (int n = 0; n < budget && send !== 1'b1; n++) @(negedge clock);
  endtask

  task automatic drain(input string name, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clock);
    check(name, exp_q.size(), 0);
    repeat (40) @(negedge clock);
  endtask

  // Scoreboard: every launch must carry the oldest byte still expected.
  always @(negedge clock) begin
    if (send === 1'b1) begin
      send_count++;
      if (exp_q.size() == 0) check("send_unexpected", 32'(send), 32'd0);
      else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  // IR transmitter model: goes busy 2 cycles after a launch, idle busy_len later.
  initial begin
    tx_available = 1'b1;
    forever begin
      @(negedge clock);
      if (send === 1'b1 && ack_mode) begin
        repeat (2) @(posedge clock);
        #1 tx_available = 1'b0;
        repeat (busy_len) @(posedge clock);
        #1 tx_available = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i <= DEPTH; i++) begin
      vecs[i] = '{wr: 1'b1, data: 8'(i), clr: 1'b0, accept: (i < DEPTH),
                  count: 5'((i < DEPTH) ? i + 1 : DEPTH), full: (i >= DEPTH - 1), ovf: (i == DEPTH)};
    end
    vecs[17] = '{wr: 1'b0, data: 8'h00, clr: 1'b1, accept: 1'b0, count: 5'd16, full: 1'b1, ovf: 1'b0};
    vecs[18] = '{wr: 1'b1, data: 8'h11, clr: 1'b1, accept: 1'b0, count: 5'd16, full: 1'b1, ovf: 1'b0};
    vecs[19] = '{wr: 1'b0, data: 8'h00, clr: 1'b0, accept: 1'b0, count: 5'd16, full: 1'b1, ovf: 1'b0};

    reset = 1'b0; wr_data = 1'b0; in_data = '0; rx_busy = 1'b0;
    uart_tx_available = 1'b1; ir_rx_raw = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_send", send, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_drop", tx_drop, 0);
    check("rst_gate", ir_rx_gated, ir_rx_raw);
    reset = 1'b1;
    @(negedge clock);

    // Single byte: launch latency, one-cycle pulse, blanking window.
    busy_len = 50;
    wr_data = 1'b1; in_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clock);
    wr_data = 1'b0;
    check("sb_count", count, 1);
    check("sb_no_early_send", send, 0);
    @(negedge clock);
    check("sb_send", send, 1);
    check("sb_out_data", out_data, 8'hA5);
    check("sb_gate_send", ir_rx_gated, RX_IDLE);
    rise = -1; sends = 0; seen_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (send === 1'b1) sends++;
      if (tx_available === 1'b0) seen_busy = 1'b1;
      else if (seen_busy && rise < 0) rise = i;
      if (rise >= 0 && i == rise) check("sb_gate_wait_done", ir_rx_gated, RX_IDLE);
      if (rise >= 0 && i == rise + GUARD) check("sb_gate_guard_end", ir_rx_gated, RX_IDLE);
      if (rise >= 0 && i == rise + GUARD + 1) begin
        check("sb_gate_reopen", ir_rx_gated, ir_rx_raw);
        check("sb_out_data_held", out_data, 8'hA5);
      end
      @(negedge clock);
    end
    check("sb_single_pulse", sends, 1);

    // Fill and overflow, table-driven, with launches held off by rx_busy.
    busy_len = 5; rx_busy = 1'b1; sc = send_count;
    for (int i = 0; i < 20; i++) begin
      wr_data = vecs[i].wr; in_data = vecs[i].data; ovf_clr = vecs[i].clr;
      if (vecs[i].accept) exp_q.push_back(vecs[i].data);
      @(negedge clock);
      check($sformatf("fill[%0d].count", i), count, vecs[i].count);
      check($sformatf("fill[%0d].full", i), full, vecs[i].full);
      check($sformatf("fill[%0d].overflow", i), overflow, vecs[i].ovf);
    end
    wr_data = 1'b0; ovf_clr = 1'b0;
    check("fill_held_no_send", send_count, sc);
    rx_busy = 1'b0;
    drain("fill_drain", 1500);
    check("fill_empty_after", empty, 1);

    // Simultaneous push and pop while full.
    rx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = 1'b1; in_data = 8'h20 + 8'(i); exp_q.push_back(in_data);
      @(negedge clock);
    end
    wr_data = 1'b0;
    check("pp_full_count", count, 16);
    check("pp_full_flag", full, 1);
    rx_busy = 1'b0; wr_data = 1'b1; in_data = 8'h30; exp_q.push_back(8'h30);
    @(negedge clock);
    wr_data = 1'b0;
    check("pp_send", send, 1);
    check("pp_count", count, 16);
    check("pp_overflow", overflow, 0);
    drain("pp_drain", 1500);

    // Acknowledge timeout, then relaunch of the next byte and flag clear.
    ack_mode = 1'b0;
    wr_data = 1'b1; in_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clock);
    in_data = 8'h66; exp_q.push_back(8'h66);
    @(negedge clock);
    wr_data = 1'b0;
    wait_send(10);
    check("ack_send", send, 1);
    repeat (ACK) @(negedge clock);
    check("ack_drop_before", tx_drop, 0);
    @(negedge clock);
    check("ack_drop_set", tx_drop, 1);
    ack_mode = 1'b1;
    lat = ACK + 1;
    while (lat < 60 && send !== 1'b1) begin
      @(negedge clock);
      lat++;
    end
    check("ack_relaunch_delay", lat, ACK + GUARD + 2);
    check("ack_drop_sticky", tx_drop, 1);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    check("ack_drop_cleared", tx_drop, 0);
    drain("ack_drain", 300);

    // Asynchronous reset during WAIT_DONE with three bytes queued.
    busy_len = 50;
    for (int i = 0; i < 4; i++) begin
      wr_data = 1'b1; in_data = 8'hC0 + 8'(i); exp_q.push_back(in_data);
      @(negedge clock);
    end
    wr_data = 1'b0;
    for (int n = 0; n < 20 && tx_available !== 1'b0; n++) @(negedge clock);
    @(negedge clock);
    check("rst_mid_count_before", count, 3);
    check("rst_mid_gate_before", ir_rx_gated, RX_IDLE);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_empty", empty, 1);
    check("rst_mid_count", count, 0);
    check("rst_mid_send", send, 0);
    check("rst_mid_gate", ir_rx_gated, ir_rx_raw);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    sc = send_count;
    repeat (80) @(negedge clock);
    check("rst_mid_no_relaunch", send_count, sc);
    check("rst_mid_still_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
